// File: rtl/ahb_apb_bridge_pkg.sv
// Shared constants for the AHB-Lite to APB3 bridge: FSM state codes,
// HTRANS encodings and HRESP values.
package ahb_apb_bridge_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_EN = 3'd1;
  localparam logic [2:0] ST_SETUP   = 3'd2;
  localparam logic [2:0] ST_ACCESS  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_ERR1    = 3'd5;
  localparam logic [2:0] ST_ERR2    = 3'd6;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Only NONSEQ/SEQ carry a real transfer; IDLE/BUSY complete with zero wait.
  function automatic logic htrans_active(input logic [1:0] htrans);
    logic active;
    case (htrans)
      HTRANS_IDLE, HTRANS_BUSY: active = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      default: active = 1'b0;
    endcase
    return active;
  endfunction

endpackage

// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge. One APB SETUP+ACCESS per AHB transfer,
// APB phases advance only on hclk edges qualified by pclken.
module ahb_to_apb_bridge
  import ahb_apb_bridge_pkg::*;
#(
  parameter int ADDRWIDTH      = 32,
  parameter bit REGISTER_RDATA = 1'b1
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 pclken,
  input  logic                 hsel,
  input  logic [ADDRWIDTH-1:0] haddr,
  input  logic [1:0]           htrans,
  input  logic                 hwrite,
  input  logic                 hready,
  input  logic [31:0]          hwdata,
  output logic                 hreadyout,
  output logic                 hresp,
  output logic [31:0]          hrdata,
  output logic [ADDRWIDTH-1:0] paddr,
  output logic                 pwrite,
  output logic [31:0]          pwdata,
  output logic                 psel,
  output logic                 penable,
  input  logic [31:0]          prdata,
  input  logic                 pslverr,
  input  logic                 pready
);

  logic [2:0]           state_q, state_d;
  logic                 hreadyout_q, hreadyout_d;
  logic                 hresp_q, hresp_d;
  logic [31:0]          hrdata_q, hrdata_d;
  logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;

  logic xfer_done_s;
  logic early_ok_s;
  logic ready_s;
  logic accept_s;

  // Unregistered mode signals completion in the ACCESS-complete cycle itself.
  always_comb begin
    xfer_done_s = (state_q == ST_ACCESS) && pclken && pready;
    early_ok_s  = (REGISTER_RDATA == 1'b0) && xfer_done_s && !pslverr;
    ready_s     = hreadyout_q || early_ok_s;
    accept_s    = hsel && hready && htrans_active(htrans) && ready_s;
  end

  always_comb begin
    state_d     = state_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    hrdata_d    = hrdata_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_WAIT_EN: begin
        // hwdata is held stable by the stalled data phase, so re-sampling is safe.
        pwdata_d = hwdata;
        if (pclken) begin
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end else begin
          state_d = ST_WAIT_EN;
        end
      end
      ST_SETUP: begin
        if (pclken) begin
          penable_d = 1'b1;
          state_d   = ST_ACCESS;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_ACCESS: begin
        if (xfer_done_s) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (pslverr) begin
            hresp_d = HRESP_ERROR;
            state_d = ST_ERR1;
          end else begin
            if (!pwrite_q) begin
              hrdata_d = prdata;
            end else begin
              hrdata_d = hrdata_q;
            end
            hreadyout_d = 1'b1;
            state_d     = REGISTER_RDATA ? ST_DONE : ST_IDLE;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_DONE: begin
        hresp_d = HRESP_OKAY;
        state_d = ST_IDLE;
      end
      ST_ERR1: begin
        hresp_d     = HRESP_ERROR;
        hreadyout_d = 1'b1;
        state_d     = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_d = HRESP_OKAY;
        state_d = ST_IDLE;
      end
      default: begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        state_d     = ST_IDLE;
      end
    endcase

    // A new address phase wins over the completion path (pipelined accept).
    if (accept_s) begin
      state_d      = ST_WAIT_EN;
      hreadyout_d  = 1'b0;
      hresp_d      = HRESP_OKAY;
      paddr_d      = haddr;
      paddr_d[1:0] = 2'b00;
      pwrite_d     = hwrite;
    end else begin
      paddr_d = paddr_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= 32'h0000_0000;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 32'h0000_0000;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
    end
  end

  assign hreadyout = ready_s;
  assign hresp     = hresp_q;
  assign hrdata    = (early_ok_s && !pwrite_q) ? prdata : hrdata_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Directed self-checking bench for ahb_to_apb_bridge (REGISTER_RDATA=1).
module tb_ahb_to_apb_bridge;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        pclken = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'h0000_0000;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic        hready = 1'b1;
  logic [31:0] hwdata = 32'h0000_0000;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic [31:0] prdata = 32'h0000_0000;
  logic        pslverr = 1'b0;
  logic        pready = 1'b1;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  bit div4 = 1'b0;

  ahb_to_apb_bridge #(.ADDRWIDTH(32), .REGISTER_RDATA(1'b1)) dut (
    .hclk(hclk), .hresetn(hresetn), .pclken(pclken), .hsel(hsel),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hready(hready),
    .hwdata(hwdata), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel),
    .penable(penable), .prdata(prdata), .pslverr(pslverr), .pready(pready)
  );

  always #5 hclk = ~hclk;

  // Advance to the next negedge; pclken is updated there for the following posedge.
  task automatic cyc();
    @(negedge hclk);
    tick_cnt = tick_cnt + 1;
    pclken = div4 ? ((tick_cnt % 4) == 0) : 1'b1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hready = 1'b1;
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  initial begin
    logic en, ps, pe, done, saw_pen;

    // Reset values
    hresetn = 1'b0;
    cyc(); cyc(); cyc();
    chk1("rst_hreadyout", hreadyout, 1'b1);
    chk1("rst_hresp", hresp, 1'b0);
    chk32("rst_hrdata", hrdata, 32'h0000_0000);
    chk32("rst_paddr", paddr, 32'h0000_0000);
    chk1("rst_pwrite", pwrite, 1'b0);
    chk32("rst_pwdata", pwdata, 32'h0000_0000);
    chk1("rst_psel", psel, 1'b0);
    chk1("rst_penable", penable, 1'b0);
    hresetn = 1'b1;
    cyc();

    // Minimum-latency write
    prdata = 32'hFFFF_0000;
    addr_phase(32'h4000_0104, 1'b1);
    cyc();
    bus_idle(); hwdata = 32'hDEAD_BEEF;
    chk1("wr_t0_hreadyout", hreadyout, 1'b0);
    chk1("wr_t0_psel", psel, 1'b0);
    chk32("wr_t0_paddr", paddr, 32'h4000_0104);
    chk1("wr_t0_pwrite", pwrite, 1'b1);
    cyc();
    chk1("wr_t1_psel", psel, 1'b1);
    chk1("wr_t1_penable", penable, 1'b0);
    chk32("wr_t1_pwdata", pwdata, 32'hDEAD_BEEF);
    cyc();
    chk1("wr_t2_psel", psel, 1'b1);
    chk1("wr_t2_penable", penable, 1'b1);
    chk1("wr_t2_hreadyout", hreadyout, 1'b0);
    cyc();
    chk1("wr_t3_hreadyout", hreadyout, 1'b1);
    chk1("wr_t3_hresp", hresp, 1'b0);
    chk1("wr_t3_psel", psel, 1'b0);
    chk1("wr_t3_penable", penable, 1'b0);
    chk32("wr_t3_hrdata_kept", hrdata, 32'h0000_0000);
    cyc();

    // Read with pclken every 4th hclk
    div4 = 1'b1;
    prdata = 32'h1234_5678;
    addr_phase(32'h4000_0008, 1'b0);
    cyc();
    bus_idle();
    chk32("div4_paddr", paddr, 32'h4000_0008);
    done = 1'b0; saw_pen = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      en = pclken; ps = psel; pe = penable;
      cyc();
      if (!en) begin
        chk1("div4_psel_hold", psel, ps);
        chk1("div4_penable_hold", penable, pe);
      end
      if (penable) saw_pen = 1'b1;
      if (hreadyout) done = 1'b1;
    end
    chk1("div4_completed", done, 1'b1);
    chk1("div4_saw_access", saw_pen, 1'b1);
    chk32("div4_hrdata", hrdata, 32'h1234_5678);
    chk1("div4_hresp", hresp, 1'b0);
    div4 = 1'b0;
    cyc();

    // pready low for 5 cycles in ACCESS
    pready = 1'b0;
    addr_phase(32'h4000_0010, 1'b1);
    cyc();
    bus_idle(); hwdata = 32'hA5A5_5A5A;
    cyc(); cyc();
    chk1("wait_access_penable", penable, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk1("wait_psel", psel, 1'b1);
      chk1("wait_penable", penable, 1'b1);
      chk32("wait_paddr", paddr, 32'h4000_0010);
      chk32("wait_pwdata", pwdata, 32'hA5A5_5A5A);
      chk1("wait_hreadyout", hreadyout, 1'b0);
    end
    pready = 1'b1;
    cyc();
    chk1("wait_end_hreadyout", hreadyout, 1'b1);
    chk1("wait_end_psel", psel, 1'b0);
    cyc();

    // PSLVERR on read -> two-cycle ERROR
    pslverr = 1'b1; prdata = 32'h0BAD_F00D;
    addr_phase(32'h4000_0020, 1'b0);
    cyc();
    bus_idle();
    cyc(); cyc(); cyc();
    chk1("err1_hresp", hresp, 1'b1);
    chk1("err1_hreadyout", hreadyout, 1'b0);
    chk1("err1_psel", psel, 1'b0);
    pslverr = 1'b0;
    cyc();
    chk1("err2_hresp", hresp, 1'b1);
    chk1("err2_hreadyout", hreadyout, 1'b1);
    cyc();
    chk1("err_idle_hresp", hresp, 1'b0);
    chk1("err_idle_hreadyout", hreadyout, 1'b1);
    chk32("err_hrdata_kept", hrdata, 32'h1234_5678);

    // BUSY ignored; unaligned address forced to word boundary
    hsel = 1'b1; htrans = 2'b01; haddr = 32'h4000_0050; hwrite = 1'b1;
    cyc(); cyc();
    chk1("busy_psel", psel, 1'b0);
    chk1("busy_hreadyout", hreadyout, 1'b1);
    prdata = 32'h00C0_FFEE;
    addr_phase(32'h4000_0003, 1'b0);
    cyc();
    bus_idle();
    chk32("align_paddr", paddr, 32'h4000_0000);
    chk1("align_hreadyout", hreadyout, 1'b0);
    cyc(); cyc(); cyc();
    chk1("align_done", hreadyout, 1'b1);
    chk32("align_hrdata", hrdata, 32'h00C0_FFEE);
    cyc();

    // Reset during ACCESS, then normal transfer and pipelined accept
    pready = 1'b0;
    addr_phase(32'h4000_0030, 1'b1);
    cyc();
    bus_idle(); hwdata = 32'h1111_2222;
    cyc(); cyc();
    chk1("rstacc_penable", penable, 1'b1);
    hresetn = 1'b0;
    cyc();
    chk1("rstacc_psel", psel, 1'b0);
    chk1("rstacc_penable_low", penable, 1'b0);
    chk1("rstacc_hreadyout", hreadyout, 1'b1);
    chk32("rstacc_paddr", paddr, 32'h0000_0000);
    chk32("rstacc_hrdata", hrdata, 32'h0000_0000);
    hresetn = 1'b1; pready = 1'b1;
    cyc();
    prdata = 32'h55AA_55AA;
    addr_phase(32'h4000_0040, 1'b0);
    cyc();
    bus_idle();
    cyc(); cyc(); cyc();
    chk1("post_rst_hreadyout", hreadyout, 1'b1);
    chk32("post_rst_hrdata", hrdata, 32'h55AA_55AA);
    addr_phase(32'h4000_0044, 1'b1);
    cyc();
    bus_idle(); hwdata = 32'h1357_9BDF;
    chk1("pipe_hreadyout", hreadyout, 1'b0);
    chk32("pipe_paddr", paddr, 32'h4000_0044);
    chk1("pipe_pwrite", pwrite, 1'b1);
    cyc(); cyc(); cyc();
    chk1("pipe_done", hreadyout, 1'b1);
    chk32("pipe_pwdata", pwdata, 32'h1357_9BDF);
    chk32("pipe_hrdata_kept", hrdata, 32'h55AA_55AA);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
